// File: rtl/reorder_buffer_param.sv
// -----------------------------------------------------------------------------
// reorder_buffer_param
//
// In-order-commit reorder buffer. Instructions are allocated in program order
// at dispatch and receive the ROB index as their tag. Execution units write
// results back by tag in any order. Entries retire strictly in order through a
// valid/ready commit port.
//
// Handshakes (all valid/ready pairs):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   valid never depends combinationally on ready. A producer holds its payload
//   stable while valid=1 and ready=0. Here alloc_ready, commit_valid and the
//   commit payload are functions of registered state only.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   alloc_valid   dispatch requests one entry
//   alloc_dest    destination register of the dispatched instruction
//   alloc_ready   an entry is free (!full)
//   alloc_tag     tag given to an allocation this cycle (tail index)
//   wb_valid      execution result valid
//   wb_tag        entry being written back
//   wb_data       result value
//   commit_valid  head entry is allocated and complete
//   commit_ready  register file accepts the commit
//   commit_data   head result        (0 when commit_valid=0)
//   commit_reg    head destination   (0 when commit_valid=0)
//   commit_tag    head index         (0 when commit_valid=0)
//   flush         discard all entries
//   count         occupied entries, 0..DEPTH
//   full          count == DEPTH
//   empty         count == 0
// -----------------------------------------------------------------------------
module reorder_buffer_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int REG_W  = 5,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [DATA_W-1:0] commit_data,
    output logic [REG_W-1:0]  commit_reg,
    output logic [IDX_W-1:0]  commit_tag,
    input  logic              flush,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty
);

    // Pointers carry one extra wrap bit so full and empty stay distinguishable
    // when the index bits coincide.
    logic [IDX_W:0]      head_q, head_d;
    logic [IDX_W:0]      tail_q, tail_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DEPTH-1:0]    done_q, done_d;
    logic [REG_W-1:0]    dest_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];

    logic [IDX_W-1:0]    head_idx;
    logic [IDX_W-1:0]    tail_idx;
    logic                alloc_fire;
    logic                commit_fire;
    logic                wb_hit;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign count = tail_q - head_q;
    assign empty = (head_q == tail_q);
    assign full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;

    assign commit_valid = busy_q[head_idx] && done_q[head_idx];
    assign commit_data  = commit_valid ? data_q[head_idx] : '0;
    assign commit_reg   = commit_valid ? dest_q[head_idx] : '0;
    assign commit_tag   = commit_valid ? head_idx         : '0;

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = commit_valid && commit_ready;
    // Looks at the pre-update busy bit, so an entry allocated this very cycle
    // (its slot is still free in busy_q) cannot be written back yet.
    assign wb_hit      = wb_valid && busy_q[wb_tag];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        busy_d = busy_q;
        done_d = done_q;

        if (alloc_fire) begin
            busy_d[tail_idx] = 1'b1;
            done_d[tail_idx] = 1'b0;
            tail_d           = tail_q + (IDX_W+1)'(1);
        end

        if (wb_hit) begin
            done_d[wb_tag] = 1'b1;
        end

        // Commit is decided on registered state, so a writeback to the head in
        // the same cycle only makes it committable next cycle. Applied last so
        // a retiring entry is always left clear.
        if (commit_fire) begin
            busy_d[head_idx] = 1'b0;
            done_d[head_idx] = 1'b0;
            head_d           = head_q + (IDX_W+1)'(1);
        end

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            busy_d = '0;
            done_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Payload storage needs no reset: it is only visible through the commit
    // port, which is gated by busy/done.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            dest_q[tail_idx] <= alloc_dest;
        end
        if (wb_hit) begin
            data_q[wb_tag] <= wb_data;
        end
    end

endmodule

// File: tb/tb_reorder_buffer_param.sv
module tb_reorder_buffer_param;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int REG_W  = 5;
  localparam int IDX_W  = 5;

  logic              clk;
  logic              reset;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [IDX_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic              commit_valid;
  logic              commit_ready;
  logic [DATA_W-1:0] commit_data;
  logic [REG_W-1:0]  commit_reg;
  logic [IDX_W-1:0]  commit_tag;
  logic              flush;
  logic [IDX_W:0]    count;
  logic              full;
  logic              empty;

  int n_cmp = 0;
  int n_err = 0;

  reorder_buffer_param #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .REG_W (REG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_dest  (alloc_dest),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .commit_valid(commit_valid),
    .commit_ready(commit_ready),
    .commit_data (commit_data),
    .commit_reg  (commit_reg),
    .commit_tag  (commit_tag),
    .flush       (flush),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs depend on registered state only; sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid  = 1'b0;
    alloc_dest   = '0;
    wb_valid     = 1'b0;
    wb_tag       = '0;
    wb_data      = '0;
    commit_ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_alloc_ready"},  32'(alloc_ready),  32'd1);
    chk({pfx, "_alloc_tag"},    32'(alloc_tag),    32'd0);
    chk({pfx, "_commit_valid"}, 32'(commit_valid), 32'd0);
    chk({pfx, "_commit_data"},  32'(commit_data),  32'd0);
    chk({pfx, "_commit_reg"},   32'(commit_reg),   32'd0);
    chk({pfx, "_commit_tag"},   32'(commit_tag),   32'd0);
    chk({pfx, "_count"},        32'(count),        32'd0);
    chk({pfx, "_full"},         32'(full),         32'd0);
    chk({pfx, "_empty"},        32'(empty),        32'd1);
  endtask

  initial begin
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] dval;
    int k;

    idle_inputs();
    reset = 1'b0;
    // Flush asserted during reset must not matter.
    flush = 1'b1;
    tick();
    reset = 1'b1;
    flush = 1'b0;
    chk_reset_outputs("rst");

    // ---- three allocations in program order
    alloc_valid = 1'b1; alloc_dest = 5'd3;
    chk("alloc0_tag", 32'(alloc_tag), 32'd0);
    tick();
    alloc_dest = 5'd7;
    chk("alloc1_tag", 32'(alloc_tag), 32'd1);
    tick();
    alloc_dest = 5'd9;
    chk("alloc2_tag", 32'(alloc_tag), 32'd2);
    tick();
    alloc_valid = 1'b0;
    chk("a3_count", 32'(count), 32'd3);
    chk("a3_empty", 32'(empty), 32'd0);
    chk("a3_cvalid", 32'(commit_valid), 32'd0);

    // ---- out-of-order writeback, in-order commit
    wb_valid = 1'b1; wb_tag = 5'd2; wb_data = 16'h00BB;
    tick();
    chk("wb2_cvalid", 32'(commit_valid), 32'd0);
    wb_tag = 5'd0; wb_data = 16'hAAAA; commit_ready = 1'b1;
    tick();
    wb_valid = 1'b0;
    chk("c0_valid", 32'(commit_valid), 32'd1);
    chk("c0_reg",   32'(commit_reg),   32'd3);
    chk("c0_data",  32'(commit_data),  32'hAAAA);
    chk("c0_tag",   32'(commit_tag),   32'd0);
    tick();
    chk("c1_wait_valid", 32'(commit_valid), 32'd0);
    chk("c1_wait_count", 32'(count), 32'd2);
    tick();
    chk("c1_wait2_valid", 32'(commit_valid), 32'd0);
    wb_valid = 1'b1; wb_tag = 5'd1; wb_data = 16'h1234;
    tick();
    wb_valid = 1'b0;
    chk("c1_valid", 32'(commit_valid), 32'd1);
    chk("c1_reg",   32'(commit_reg),   32'd7);
    chk("c1_data",  32'(commit_data),  32'h1234);
    tick();
    chk("c2_valid", 32'(commit_valid), 32'd1);
    chk("c2_reg",   32'(commit_reg),   32'd9);
    chk("c2_data",  32'(commit_data),  32'h00BB);
    chk("c2_tag",   32'(commit_tag),   32'd2);
    tick();
    commit_ready = 1'b0;
    chk("c3_valid", 32'(commit_valid), 32'd0);
    chk("c3_empty", 32'(empty), 32'd1);

    // ---- flush from a non-zero pointer position, then fill to full
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_reset_outputs("fl1");
    alloc_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_dest = REG_W'(i);
      chk("fill_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    // alloc_valid still high: the 33rd request must be ignored
    chk("full_full",  32'(full), 32'd1);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_count", 32'(count), 32'd32);
    tick();
    alloc_valid = 1'b0;
    chk("full33_count", 32'(count), 32'd32);
    chk("full33_tag",   32'(alloc_tag), 32'd0);

    // Commit while full: alloc in that cycle still refused
    wb_valid = 1'b1; wb_tag = 5'd0; wb_data = 16'h0303;
    tick();
    wb_valid = 1'b0;
    chk("fc_valid", 32'(commit_valid), 32'd1);
    chk("fc_ready", 32'(alloc_ready), 32'd0);
    commit_ready = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd5;
    tick();
    commit_ready = 1'b0;
    chk("fc_count", 32'(count), 32'd31);
    chk("fc_aready", 32'(alloc_ready), 32'd1);
    chk("fc_atag", 32'(alloc_tag), 32'd0);
    alloc_dest = 5'd6;
    tick();
    alloc_valid = 1'b0;
    chk("refill_full", 32'(full), 32'd1);

    // ---- backpressure: head (tag1) done, commit_ready low for 4 cycles
    wb_valid = 1'b1; wb_tag = 5'd1; wb_data = 16'hBEEF;
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(commit_valid), 32'd1);
      chk("bp_data",  32'(commit_data),  32'hBEEF);
      chk("bp_tag",   32'(commit_tag),   32'd1);
      chk("bp_count", 32'(count),        32'd32);
      tick();
    end
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    chk("bp_post_count", 32'(count), 32'd31);
    chk("bp_post_valid", 32'(commit_valid), 32'd0);
    chk("bp_post_tag",   32'(commit_tag), 32'd0);

    // Writeback and commit_ready on the head in the same cycle: no commit yet
    wb_valid = 1'b1; wb_tag = 5'd2; wb_data = 16'h2020; commit_ready = 1'b1;
    tick();
    chk("wbc_count", 32'(count), 32'd31);
    chk("wbc_valid", 32'(commit_valid), 32'd1);
    chk("wbc_tag",   32'(commit_tag), 32'd2);
    wb_tag = 5'd3; wb_data = 16'h1111;
    tick();
    chk("wbc2_count", 32'(count), 32'd30);
    // Repeated writeback overwrites the done entry
    wb_tag = 5'd3; wb_data = 16'h2222; commit_ready = 1'b0;
    tick();
    wb_valid = 1'b0;
    chk("rewb_valid", 32'(commit_valid), 32'd1);
    chk("rewb_data",  32'(commit_data), 32'h2222);
    chk("rewb_reg",   32'(commit_reg), 32'd3);

    // ---- fill 20, writeback 10, flush with alloc/wb/commit all active
    flush = 1'b1;
    tick();
    flush = 1'b0;
    alloc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      alloc_dest = REG_W'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    wb_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_tag = IDX_W'(i); wb_data = DATA_W'(16'h0100 + i);
      tick();
    end
    chk("f20_count", 32'(count), 32'd20);
    chk("f20_valid", 32'(commit_valid), 32'd1);
    chk("f20_data",  32'(commit_data), 32'h0100);
    flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd30;
    wb_tag = 5'd10; wb_data = 16'hDEAD; commit_ready = 1'b1;
    tick();
    idle_inputs();
    chk_reset_outputs("fl2");
    // Entries were cleared, so a writeback to tag0 is ignored
    wb_valid = 1'b1; wb_tag = 5'd0; wb_data = 16'h7777;
    tick();
    wb_valid = 1'b0;
    chk("flwb_valid", 32'(commit_valid), 32'd0);
    chk("flwb_count", 32'(count), 32'd0);

    // ---- 100 round trips in batches of 4: alloc, reverse writeback, commit
    for (int b = 0; b < 25; b++) begin
      alloc_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
        k = 4 * b + j;
        alloc_dest = REG_W'((k * 7) % 32);
        chk("rt_alloc_tag", 32'(alloc_tag), 32'(k % 32));
        tick();
      end
      alloc_valid = 1'b0;
      chk("rt_count", 32'(count), 32'd4);
      wb_valid = 1'b1;
      for (int j = 3; j >= 0; j--) begin
        k = 4 * b + j;
        wb_tag  = IDX_W'(k % 32);
        wb_data = DATA_W'(k * 16'h0101 + 1);
        tick();
        if (j == 3) chk("rt_pre_valid", 32'(commit_valid), 32'd0);
      end
      wb_valid = 1'b0;
      commit_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
        k = 4 * b + j;
        dest = REG_W'((k * 7) % 32);
        dval = DATA_W'(k * 16'h0101 + 1);
        chk("rt_valid", 32'(commit_valid), 32'd1);
        chk("rt_reg",   32'(commit_reg), 32'(dest));
        chk("rt_data",  32'(commit_data), 32'(dval));
        chk("rt_tag",   32'(commit_tag), 32'(k % 32));
        tick();
      end
      commit_ready = 1'b0;
      chk("rt_empty", 32'(empty), 32'd1);
    end

    // Writeback to an already-committed tag (4, next tail) is ignored; the
    // freshly allocated entry there must not appear complete.
    wb_valid = 1'b1; wb_tag = 5'd4; wb_data = 16'h4444;
    tick();
    wb_valid = 1'b0;
    chk("stale_valid", 32'(commit_valid), 32'd0);
    chk("stale_empty", 32'(empty), 32'd1);
    alloc_valid = 1'b1; alloc_dest = 5'd12;
    chk("stale_atag", 32'(alloc_tag), 32'd4);
    tick();
    alloc_valid = 1'b0;
    chk("stale_alloc_valid", 32'(commit_valid), 32'd0);
    chk("stale_alloc_count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
